mem_port_arbiter: RTL and testbench

Shares one single-ported synchronous SRAM between the CPU's instruction-fetch port and its data (load/store) port. Sits between the core's fetch/memory stages and the unified memory. Each requester uses a req / addr_ok / data_ok handshake. At most one access is granted per cycle, and the response is returned to the correct requester exactly one cycle after grant.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb2_pick.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data SRAM port arbiter: response FSM states
// and requester owner encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb2_pick.sv
// Two-way grant picker for the fetch and data requesters.
// ARB_RR_EN selects round-robin; otherwise data wins over instruction.
module arb2_pick
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
`ifdef ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_i,
  output logic grant_d
);

  // Resolve a single grant from the two requests
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
`ifdef ARB_RR_EN
      // On conflict the side that did not win last time goes first
      if (last_grant == OWN_I) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
`else
      grant_d = 1'b1;
`endif
    end else if (req_d) begin
      grant_d = 1'b1;
    end else if (req_i) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM between instruction fetch and data ports; the
// response returns one cycle after grant. ARB_RR_EN enables round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_t state_r;
  state_t next_state_s;
  logic   resp_wr_r;
  logic   req_i_s;
  logic   req_d_s;
  logic   grant_i_s;
  logic   grant_d_s;

  // Requests are masked while reset is held so nothing is granted or answered
  assign req_i_s = inst_req & ~reset;
  assign req_d_s = data_req & ~reset;

`ifdef ARB_RR_EN
  logic last_grant_r;

  arb2_pick u_pick (
    .req_i      (req_i_s),
    .req_d      (req_d_s),
    .last_grant (last_grant_r),
    .grant_i    (grant_i_s),
    .grant_d    (grant_d_s)
  );

  // Round-robin pointer: remembers the owner of the most recent grant
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= OWN_I;
    end else if (grant_i_s) begin
      last_grant_r <= OWN_I;
    end else if (grant_d_s) begin
      last_grant_r <= OWN_D;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  arb2_pick u_pick (
    .req_i   (req_i_s),
    .req_d   (req_d_s),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );
`endif

  // SRAM request mux driven from the winning requester
  always_comb begin
    inst_addr_ok = grant_i_s;
    data_addr_ok = grant_d_s;
    sram_en      = grant_i_s | grant_d_s;
    sram_wdata   = data_wdata;
    if (grant_d_s) begin
      sram_addr = data_addr;
    end else begin
      sram_addr = inst_addr;
    end
    if (grant_d_s && data_wr) begin
      sram_we = data_wstrb;
    end else begin
      sram_we = {STRB_W{1'b0}};
    end
  end

  // Response owner register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next owner follows this cycle's grant; no grant means no response
  always_comb begin
    next_state_s = IDLE;
    if (grant_i_s) begin
      next_state_s = RESP_I;
    end else if (grant_d_s) begin
      next_state_s = RESP_D;
    end else begin
      next_state_s = IDLE;
    end
  end

  // Remember whether the outstanding data access was a store
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_wr_r <= 1'b0;
    end else if (grant_d_s) begin
      resp_wr_r <= data_wr;
    end else begin
      resp_wr_r <= resp_wr_r;
    end
  end

  // Response outputs; a reset in the response cycle drops the response
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = sram_rdata;
    if (resp_wr_r) begin
      data_rdata = {DATA_W{1'b0}};
    end else begin
      data_rdata = sram_rdata;
    end
    case (state_r)
      RESP_I:  inst_data_ok = ~reset;
      RESP_D:  data_data_ok = ~reset;
      IDLE:    begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
      end
      default: begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural SRAM;
// expectations follow ARB_RR_EN for the conflict scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous SRAM with byte write enables
  always @(posedge clk) begin
    logic [31:0] cur;
    if (sram_en) begin
      cur = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      sram_rdata <= cur;
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) cur[b*8 +: 8] = sram_wdata[b*8 +: 8];
      end
      mem[sram_addr] = cur;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    mem[32'h1C000000] = 32'h02800421;
    mem[32'h00000100] = 32'h00000000;
    mem[32'h00000204] = 32'h11223344;
    reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    tick(); tick();
    chk("rst_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
    chk("rst_data_addr_ok", {31'h0, data_addr_ok}, 32'h0);
    chk("rst_inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
    chk("rst_data_data_ok", {31'h0, data_data_ok}, 32'h0);
    chk("rst_sram_en", {31'h0, sram_en}, 32'h0);
    chk("rst_sram_we", {28'h0, sram_we}, 32'h0);
    reset = 1'b0;

    // Lone fetch
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C000000; settle();
    chk("fetch_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
    chk("fetch_sram_en", {31'h0, sram_en}, 32'h1);
    chk("fetch_sram_addr", sram_addr, 32'h1C000000);
    chk("fetch_sram_we", {28'h0, sram_we}, 32'h0);
    tick();
    inst_req = 1'b0; settle();
    chk("fetch_data_ok", {31'h0, inst_data_ok}, 32'h1);
    chk("fetch_rdata", inst_rdata, 32'h02800421);
    chk("fetch_no_d_ok", {31'h0, data_data_ok}, 32'h0);
    chk("fetch_idle_en", {31'h0, sram_en}, 32'h0);
    tick();
    chk("fetch_ok_once", {31'h0, inst_data_ok}, 32'h0);

    // Store then load at 0x100
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEADBEEF;
    settle();
    chk("st_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    chk("st_sram_we", {28'h0, sram_we}, 32'hF);
    chk("st_sram_addr", sram_addr, 32'h100);
    chk("st_sram_wdata", sram_wdata, 32'hDEADBEEF);
    tick();
    data_wr = 1'b0; data_wstrb = 4'h0; settle();
    chk("st_data_ok", {31'h0, data_data_ok}, 32'h1);
    chk("ld_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    chk("ld_sram_we", {28'h0, sram_we}, 32'h0);
    tick();
    data_req = 1'b0; settle();
    chk("ld_data_ok", {31'h0, data_data_ok}, 32'h1);
    chk("ld_rdata", data_rdata, 32'hDEADBEEF);
    tick();
    chk("ld_ok_once", {31'h0, data_data_ok}, 32'h0);

    // Byte store to 0x204, then read back the merged word
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0010; data_addr = 32'h204; data_wdata = 32'h0000AB00;
    settle();
    chk("bst_sram_we", {28'h0, sram_we}, 32'h2);
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; settle();
    chk("bst_we_once", {28'h0, sram_we}, 32'h0);
    chk("bst_data_ok", {31'h0, data_data_ok}, 32'h1);
    tick();
    data_req = 1'b1; settle();
    chk("bld_addr_ok", {31'h0, data_addr_ok}, 32'h1);
    tick();
    data_req = 1'b0; settle();
    chk("bld_rdata", data_rdata, 32'h1122AB44);
    tick();

    // Reset while a fetch response is pending
    inst_req = 1'b1; inst_addr = 32'h1C000000; settle();
    chk("rmf_grant", {31'h0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 1'b0; reset = 1'b1; settle();
    chk("rmf_ok_n1", {31'h0, inst_data_ok}, 32'h0);
    tick();
    reset = 1'b0; settle();
    chk("rmf_ok_n2", {31'h0, inst_data_ok}, 32'h0);
    chk("rmf_d_ok_n2", {31'h0, data_data_ok}, 32'h0);
    tick();

    // Both requesters held
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h100;
`ifdef ARB_RR_EN
    settle();
    chk("rr_c0_d", {31'h0, data_addr_ok}, 32'h1);
    chk("rr_c0_i", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    chk("rr_c1_i", {31'h0, inst_addr_ok}, 32'h1);
    chk("rr_c1_d", {31'h0, data_addr_ok}, 32'h0);
    chk("rr_c1_dok", {31'h0, data_data_ok}, 32'h1);
    chk("rr_c1_drd", data_rdata, 32'hDEADBEEF);
    tick();
    chk("rr_c2_d", {31'h0, data_addr_ok}, 32'h1);
    chk("rr_c2_iok", {31'h0, inst_data_ok}, 32'h1);
    chk("rr_c2_ird", inst_rdata, 32'h02800421);
    tick();
    chk("rr_c3_i", {31'h0, inst_addr_ok}, 32'h1);
    chk("rr_c3_dok", {31'h0, data_data_ok}, 32'h1);
    tick();
    inst_req = 1'b0; data_req = 1'b0; settle();
    chk("rr_c4_iok", {31'h0, inst_data_ok}, 32'h1);
    chk("rr_c4_dok", {31'h0, data_data_ok}, 32'h0);
`else
    settle();
    chk("fp_c0_d", {31'h0, data_addr_ok}, 32'h1);
    chk("fp_c0_i", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    chk("fp_c1_d", {31'h0, data_addr_ok}, 32'h1);
    chk("fp_c1_i", {31'h0, inst_addr_ok}, 32'h0);
    chk("fp_c1_dok", {31'h0, data_data_ok}, 32'h1);
    tick();
    chk("fp_c2_d", {31'h0, data_addr_ok}, 32'h1);
    chk("fp_c2_i", {31'h0, inst_addr_ok}, 32'h0);
    tick();
    data_req = 1'b0; settle();
    chk("fp_c3_i", {31'h0, inst_addr_ok}, 32'h1);
    chk("fp_c3_dok", {31'h0, data_data_ok}, 32'h1);
    chk("fp_c3_drd", data_rdata, 32'hDEADBEEF);
    tick();
    inst_req = 1'b0; settle();
    chk("fp_c4_iok", {31'h0, inst_data_ok}, 32'h1);
    chk("fp_c4_ird", inst_rdata, 32'h02800421);
`endif
    tick();
    chk("end_idle_iok", {31'h0, inst_data_ok}, 32'h0);
    chk("end_idle_dok", {31'h0, data_data_ok}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
